// File: rtl/wb_spim_pkg.sv
// Shared definitions for the Wishbone SPI master: register offsets, bit indices
// and shift engine state encoding.
package wb_spim_pkg;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;

    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_DONE  = 1;
    localparam int unsigned ST_OVR   = 2;
    localparam int unsigned CTRL_CSN = 8;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} spim_state_e;

endpackage

// File: rtl/spim_shift.sv
// SPI mode 0 shift engine: half-period divider, one-byte MSB-first transfer.
module spim_shift
    import wb_spim_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             start_i,
    input  logic [7:0]       tx_byte_i,
    input  logic             miso_i,
    output logic             busy_o,
    output logic [7:0]       rx_byte_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             mosi_o
);

    spim_state_e      state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       tx_q;
    logic [7:0]       rx_sr_q;

    // Completion is flagged on the edge that clears busy so the register side can
    // set done on that very edge.
    assign done_o = (state_q == HIGH) && (cnt_q == '0) && (bit_q == 3'd7);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_byte_o <= '0;
            busy_o    <= 1'b0;
            sclk_o    <= 1'b0;
            mosi_o    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= LOW;
                        tx_q    <= tx_byte_i;
                        mosi_o  <= tx_byte_i[7];
                        bit_q   <= '0;
                        cnt_q   <= div_i;
                        busy_o  <= 1'b1;
                    end
                end
                LOW: begin
                    if (cnt_q == '0) begin
                        state_q <= HIGH;
                        sclk_o  <= 1'b1;
                        rx_sr_q <= {rx_sr_q[6:0], miso_i};
                        cnt_q   <= div_i;
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt_q == '0) begin
                        sclk_o <= 1'b0;
                        if (bit_q == 3'd7) begin
                            state_q   <= IDLE;
                            mosi_o    <= 1'b0;
                            rx_byte_o <= rx_sr_q;
                            busy_o    <= 1'b0;
                        end else begin
                            state_q <= LOW;
                            tx_q    <= {tx_q[6:0], 1'b0};
                            mosi_o  <= tx_q[6];
                            bit_q   <= bit_q + 3'd1;
                            cnt_q   <= div_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_spim.sv
// Wishbone classic slave exposing a one-byte SPI master through a four-word
// register window (DATA, STATUS, CTRL, reserved).
module wb_spim
    import wb_spim_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 3
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat,
    output logic [31:0] wb_rdt,
    output logic        wb_ack,
    output logic        spi_csn,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        done_irq
);

    logic [DIV_W-1:0] div_q;
    logic             csn_q;
    logic             done_q;
    logic             ovr_q;
    logic             busy;
    logic             done_pulse;
    logic [7:0]       rx_byte;

    logic        acc, wr, rd, data_wr, start;
    logic [1:0]  adr;
    logic [31:0] status_w, ctrl_w, rd_mux;

    logic unused_bits;
    assign unused_bits = ^{wb_adr[31:4], wb_adr[1:0], wb_dat[31:9], wb_sel[3:2]};

    always_comb begin
        adr     = wb_adr[3:2];
        acc     = wb_cyc & wb_stb & ~wb_ack;
        wr      = acc & wb_we;
        rd      = acc & ~wb_we;
        data_wr = wr & (adr == ADR_DATA) & wb_sel[0];
        start   = data_wr & ~busy;

        status_w          = '0;
        status_w[ST_BUSY] = busy;
        status_w[ST_DONE] = done_q;
        status_w[ST_OVR]  = ovr_q;

        ctrl_w            = '0;
        ctrl_w[DIV_W-1:0] = div_q;
        ctrl_w[CTRL_CSN]  = csn_q;

        case (adr)
            ADR_DATA:   rd_mux = {24'b0, rx_byte};
            ADR_STATUS: rd_mux = status_w;
            ADR_CTRL:   rd_mux = ctrl_w;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wb_ack <= 1'b0;
            wb_rdt <= '0;
            div_q  <= DIV_W'(DIV_RST);
            csn_q  <= 1'b1;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            wb_ack <= acc;
            wb_rdt <= rd ? rd_mux : '0;
            if (wr && adr == ADR_CTRL) begin
                if (wb_sel[0]) div_q <= wb_dat[DIV_W-1:0];
                if (wb_sel[1]) csn_q <= wb_dat[CTRL_CSN];
            end
            if (data_wr && busy) begin
                ovr_q <= 1'b1;
            end else if (wr && adr == ADR_STATUS && wb_sel[0] && wb_dat[ST_OVR]) begin
                ovr_q <= 1'b0;
            end
            // A completion on the same edge as a DATA read wins over the clear.
            if (done_pulse) begin
                done_q <= 1'b1;
            end else if (rd && adr == ADR_DATA) begin
                done_q <= 1'b0;
            end
        end
    end

    assign spi_csn  = csn_q;
    assign done_irq = done_q;

    spim_shift #(
        .DIV_W(DIV_W)
    ) u_shift (
        .clk_i    (wb_clk),
        .rst_i    (wb_rst),
        .div_i    (div_q),
        .start_i  (start),
        .tx_byte_i(wb_dat[7:0]),
        .miso_i   (spi_miso),
        .busy_o   (busy),
        .rx_byte_o(rx_byte),
        .done_o   (done_pulse),
        .sclk_o   (spi_clk),
        .mosi_o   (spi_mosi)
    );

endmodule
